// File: rtl/sym_fir_pipe.sv
// Symmetric linear-phase FIR: pre-add, multiply, adder tree, round/saturate in a
// valid-tagged 5-stage pipeline, with a shadow/active coefficient bank pair.
module sym_fir_pipe #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int TAPS  = 32,
    parameter int SHIFT = 15,
    localparam int NC   = TAPS / 2,
    localparam int AW   = $clog2(NC)
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Clr,
    input  logic                 i_Coe_We,
    input  logic [AW-1:0]        i_Coe_Addr,
    input  logic signed [CW-1:0] i_Coe_Data,
    input  logic                 i_Coe_Commit,
    output logic                 o_Coe_Busy,
    input  logic                 i_Vld,
    input  logic signed [DW-1:0] i_Din,
    output logic                 o_Vld,
    output logic signed [DW-1:0] o_Dout,
    output logic                 o_Sat
);

    localparam int PW   = DW + 1 + CW;
    localparam int ACCW = PW + $clog2(NC);
    localparam int RW   = ACCW + 1;
    localparam int FW   = $clog2(TAPS + 1);
    localparam logic signed [RW-1:0] RND  = RW'(1) << (SHIFT - 1);
    localparam logic signed [RW-1:0] MAXV = {{(RW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [RW-1:0] MINV = {{(RW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [DW-1:0] r_dl     [TAPS];
    logic signed [CW-1:0] r_shadow [NC];
    logic signed [CW-1:0] r_active [NC];
    logic signed [DW:0]   r_pre    [NC];
    logic signed [PW-1:0] r_prod   [NC];
    logic signed [ACCW-1:0] r_acc;
    logic [FW-1:0]        r_fill;
    logic                 r_v0, r_v1, r_v2, r_v3, r_vo;
    logic                 r_pend;
    logic signed [DW-1:0] r_dout;
    logic                 r_sat;

    logic                 w_take;
    logic signed [ACCW-1:0] w_sum;
    logic signed [RW-1:0] w_rnd;
    logic signed [RW-1:0] w_shr;

    assign w_take = i_Vld && !i_Clr;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NC; k++) begin
            w_sum = w_sum + ACCW'(r_prod[k]);
        end
    end

    assign w_rnd = {r_acc[ACCW-1], r_acc} + RND;
    assign w_shr = w_rnd >>> SHIFT;

    // Datapath and valid tags; the delay line only moves on accepted samples
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            for (int k = 0; k < TAPS; k++) r_dl[k] <= '0;
            for (int k = 0; k < NC; k++) begin
                r_pre[k]  <= '0;
                r_prod[k] <= '0;
            end
            r_acc  <= '0;
            r_fill <= '0;
            r_v0   <= 1'b0;
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
        end else begin
            for (int k = 0; k < NC; k++) begin
                r_pre[k]  <= {r_dl[k][DW-1], r_dl[k]} + {r_dl[TAPS-1-k][DW-1], r_dl[TAPS-1-k]};
                r_prod[k] <= PW'(r_pre[k]) * PW'(r_active[k]);
            end
            r_acc <= w_sum;
            if (i_Clr) begin
                for (int k = 0; k < TAPS; k++) r_dl[k] <= '0;
                r_fill <= '0;
                r_v0   <= 1'b0;
                r_v1   <= 1'b0;
                r_v2   <= 1'b0;
                r_v3   <= 1'b0;
            end else begin
                if (w_take) begin
                    for (int k = TAPS - 1; k > 0; k--) r_dl[k] <= r_dl[k-1];
                    r_dl[0] <= i_Din;
                    if (r_fill != FW'(TAPS)) r_fill <= r_fill + 1'b1;
                end
                r_v0 <= w_take && (r_fill >= FW'(TAPS - 1));
                r_v1 <= r_v0;
                r_v2 <= r_v1;
                r_v3 <= r_v2;
            end
        end
    end

    // Bank swap waits until S1/S2 hold no valid sample so no output mixes banks
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            for (int k = 0; k < NC; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_pend <= 1'b0;
        end else begin
            if (i_Coe_We && ({1'b0, i_Coe_Addr} < (AW+1)'(NC))) begin
                r_shadow[i_Coe_Addr] <= i_Coe_Data;
            end
            if (r_pend && !r_v1 && !r_v2) begin
                r_active <= r_shadow;
                r_pend   <= 1'b0;
            end else if (i_Coe_Commit) begin
                r_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_vo   <= 1'b0;
            r_dout <= '0;
            r_sat  <= 1'b0;
        end else begin
            r_vo <= r_v3 && !i_Clr;
            if (r_v3) begin
                if (w_shr > MAXV) begin
                    r_dout <= MAXV[DW-1:0];
                    r_sat  <= 1'b1;
                end else if (w_shr < MINV) begin
                    r_dout <= MINV[DW-1:0];
                    r_sat  <= 1'b1;
                end else begin
                    r_dout <= w_shr[DW-1:0];
                    r_sat  <= 1'b0;
                end
            end
        end
    end

    assign o_Vld      = r_vo;
    assign o_Dout     = r_dout;
    assign o_Sat      = r_sat;
    assign o_Coe_Busy = r_pend;

endmodule

// File: tb/tb_sym_fir_pipe.sv
// Bench for sym_fir_pipe: direct-form reference model over accepted-sample history,
// expected outputs queued with their due cycle and checked every cycle.
module tb_sym_fir_pipe;
    localparam int DW = 16, CW = 16, TAPS = 32, SHIFT = 15, NC = 16, AW = 4;

    logic clk = 1'b0;
    logic rst_n, clr, coe_we, coe_commit, busy, vld_i, vld_o, sat;
    logic [AW-1:0] coe_addr;
    logic signed [CW-1:0] coe_data;
    logic signed [DW-1:0] din, dout;

    always #5 clk = ~clk;

    sym_fir_pipe #(.DW(DW), .CW(CW), .TAPS(TAPS), .SHIFT(SHIFT)) dut (
        .i_Clk(clk), .i_Rst(rst_n), .i_Clr(clr), .i_Coe_We(coe_we),
        .i_Coe_Addr(coe_addr), .i_Coe_Data(coe_data), .i_Coe_Commit(coe_commit),
        .o_Coe_Busy(busy), .i_Vld(vld_i), .i_Din(din), .o_Vld(vld_o),
        .o_Dout(dout), .o_Sat(sat)
    );

    typedef struct { int due; int val; bit sat; } exp_t;

    int   cyc = 0;
    int   n_chk = 0, n_pass = 0;
    int   m_shadow[NC], m_active[NC], hb[NC], stim[48], ref_out[$];
    int   hist[$], rec[$];
    int   m_fill = 0;
    exp_t expq[$];
    bit   last_sat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // y = sum h[k]*(x[n-k] + x[n-TAPS+1+k]), round half up, clip to DW bits
    function automatic void fir_ref(input int h[NC], input int xs[TAPS], output int y, output bit s);
        longint acc = 0, r;
        for (int k = 0; k < NC; k++) acc += longint'(h[k]) * longint'(xs[k] + xs[TAPS-1-k]);
        r = (acc + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        s = 1'b0;
        y = int'(r);
        if (r > 32767) begin y = 32767; s = 1'b1; end
        else if (r < -32768) begin y = -32768; s = 1'b1; end
    endfunction

    always @(negedge clk) begin
        if (expq.size() > 0 && expq[0].due == cyc) begin
            check("o_Vld on time", vld_o, 1);
            if (vld_o) begin
                check("o_Dout", dout, expq[0].val);
                check("o_Sat", sat, expq[0].sat);
            end
            void'(expq.pop_front());
        end else begin
            check("o_Vld idle", vld_o, 0);
        end
        if (vld_o) begin
            rec.push_back(int'(dout));
            last_sat = sat;
        end
    end

    // Drives one cycle of inputs (called at posedge+2) and updates the model
    task automatic step(input bit v, input int x, input bit c = 0, input bit we = 0,
                        input int addr = 0, input int data = 0, input bit cm = 0);
        int xs[TAPS];
        int y;
        bit s;
        vld_i = v; din = DW'(x); clr = c; coe_we = we;
        coe_addr = AW'(addr); coe_data = CW'(data); coe_commit = cm;
        if (we) m_shadow[addr] = data;
        if (c) begin
            hist.delete();
            m_fill = 0;
            while (expq.size() > 0 && expq[expq.size()-1].due > cyc) void'(expq.pop_back());
        end else if (v) begin
            hist.push_front(x);
            if (hist.size() > TAPS) void'(hist.pop_back());
            if (m_fill >= TAPS - 1) begin
                for (int k = 0; k < TAPS; k++) xs[k] = (k < hist.size()) ? hist[k] : 0;
                fir_ref(m_active, xs, y, s);
                expq.push_back('{due: cyc + 5, val: y, sat: s});
            end
            if (m_fill < TAPS) m_fill++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0);
    endtask

    task automatic load_bank();
        for (int k = 0; k < NC; k++) step(0, 0, 0, 1, k, hb[k], 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("busy after idle commit", busy, 1);
        step(0, 0);
        check("busy cleared after idle commit", busy, 0);
        m_active = m_shadow;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin m_shadow[k] = 0; m_active[k] = 0; end
        hist.delete();
        expq.delete();
        m_fill = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int xs[TAPS];
        int y, n;
        bit s;
        rst_n = 1'b0; clr = 0; coe_we = 0; coe_commit = 0; vld_i = 0;
        coe_addr = '0; coe_data = '0; din = '0;
        model_reset();

        // pin the reference model with hand-computed values
        for (int k = 0; k < NC; k++) hb[k] = 0;
        for (int k = 0; k < TAPS; k++) xs[k] = 0;
        hb[0] = 16384; xs[0] = 1000;
        fir_ref(hb, xs, y, s);   check("model impulse 1000", y, 500);
        hb[0] = 1; xs[0] = 16384;
        fir_ref(hb, xs, y, s);   check("model half up", y, 1);
        xs[0] = -16384;
        fir_ref(hb, xs, y, s);   check("model -half", y, 0);
        for (int k = 0; k < NC; k++) hb[k] = 32767;
        for (int k = 0; k < TAPS; k++) xs[k] = 32767;
        fir_ref(hb, xs, y, s);   check("model sat val", y, 32767); check("model sat flag", s, 1);

        @(posedge clk); #2;
        check("reset o_Vld", vld_o, 0);
        check("reset o_Dout", dout, 0);
        check("reset o_Sat", sat, 0);
        check("reset busy", busy, 0);
        rst_n = 1'b1;
        idle(2);

        // impulse through h[0]=0.5
        for (int k = 0; k < NC; k++) hb[k] = 0;
        hb[0] = 16384;
        load_bank();
        rec.delete();
        for (int i = 0; i < 31; i++) step(1, 0);
        step(1, 1000);
        for (int i = 0; i < 31; i++) step(1, 0);
        idle(6);
        check("t1 output count", rec.size(), 32);
        if (rec.size() == 32) begin
            check("t1 first output", rec[0], 500);
            check("t1 second output", rec[1], 0);
            check("t1 mirror tap output", rec[31], 500);
        end

        // DC saturation both polarities
        for (int k = 0; k < NC; k++) hb[k] = 32767;
        load_bank();
        rec.delete();
        for (int i = 0; i < 32; i++) step(1, 32767);
        idle(6);
        check("t2 +dc value", rec[rec.size()-1], 32767);
        check("t2 +dc sat", last_sat, 1);
        for (int i = 0; i < 32; i++) step(1, -32768);
        idle(6);
        check("t2 -dc value", rec[rec.size()-1], -32768);
        check("t2 -dc sat", last_sat, 1);

        // rounding at exactly one half
        for (int k = 0; k < NC; k++) hb[k] = 0;
        hb[0] = 1;
        load_bank();
        step(0, 0, 1);
        rec.delete();
        for (int i = 0; i < 31; i++) step(1, 0);
        step(1, 16384);
        for (int i = 0; i < 31; i++) step(1, 0);
        step(1, -16384);
        idle(6);
        check("t3 output count", rec.size(), 33);
        if (rec.size() == 33) begin
            check("t3 +half rounds up", rec[0], 1);
            check("t3 mirror +half", rec[31], 1);
            check("t3 -half", rec[32], 0);
        end

        // identical results with and without input gaps
        for (int k = 0; k < NC; k++) hb[k] = (k % 2 == 1) ? -(1000 * (k + 1)) : 1000 * (k + 1);
        load_bank();
        for (int i = 0; i < 48; i++) stim[i] = int'($urandom_range(0, 65535)) - 32768;
        step(0, 0, 1);
        rec.delete();
        for (int i = 0; i < 48; i++) step(1, stim[i]);
        idle(6);
        ref_out = rec;
        step(0, 0, 1);
        rec.delete();
        for (int i = 0; i < 48; i++) begin
            while ($urandom_range(0, 9) < 3) step(0, 0);
            step(1, stim[i]);
        end
        idle(6);
        check("t4 gap output count", rec.size(), ref_out.size());
        n = (rec.size() < ref_out.size()) ? rec.size() : ref_out.size();
        for (int i = 0; i < n; i++) check("t4 gap vs gapless", rec[i], ref_out[i]);

        // commit under full-rate stream: stays pending until the stream pauses
        for (int i = 0; i < 40; i++) begin
            step(1, int'($urandom_range(0, 65535)) - 32768, 0, (i < 16), i % NC,
                 (i % 3 == 0) ? 20000 - 977 * i : -3000 + 411 * i, (i == 15));
            if (i >= 16) check("t5 busy during stream", busy, 1);
        end
        n = 0;
        while (busy && n < 8) begin step(0, 0); n++; end
        check("t5 busy clears after stream", busy, 0);
        m_active = m_shadow;
        for (int i = 0; i < 20; i++) step(1, int'($urandom_range(0, 65535)) - 32768);
        idle(6);

        // clear mid-stream (same-cycle sample dropped), refill, coefficients kept
        for (int i = 0; i < 10; i++) step(1, 500 * i - 2000);
        step(1, 12345, 1);
        rec.delete();
        for (int i = 0; i < 31; i++) step(1, 700 * i - 9000);
        idle(6);
        check("t6 no output before refill", rec.size(), 0);
        step(1, 3000);
        idle(6);
        check("t6 first output after refill", rec.size(), 1);

        // reset mid-stream discards in-flight outputs and both banks
        for (int i = 0; i < 10; i++) step(1, 1111 * i);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid reset o_Vld", vld_o, 0);
        check("mid reset o_Dout", dout, 0);
        check("mid reset o_Sat", sat, 0);
        check("mid reset busy", busy, 0);
        step(0, 0);
        rst_n = 1'b1;
        step(0, 0);
        rec.delete();
        for (int i = 0; i < 40; i++) step(1, int'($urandom_range(0, 65535)) - 32768);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0);
        for (int i = 0; i < 5; i++) step(1, 30000);
        idle(6);
        check("post-reset output count", rec.size(), 14);
        if (rec.size() > 0) check("post-reset zero bank output", rec[rec.size()-1], 0);
        check("drain", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
